// File: rtl/line_request_latch_if.sv
// Request bundle between raw request lines, the latch and its consumer.
// Carries the sticky overrun vector when LINE_REQ_OVERRUN_EN is defined.
interface line_request_latch_if;
  logic [7:0] raw_in;
  logic       ack;
  logic [7:0] req_onehot;
  logic       req_valid;
  logic [7:0] pending;
`ifdef LINE_REQ_OVERRUN_EN
  logic [7:0] overrun;
`endif

  modport master (
    output raw_in,
    output ack,
    input  req_onehot,
    input  req_valid,
`ifdef LINE_REQ_OVERRUN_EN
    input  overrun,
`endif
    input  pending
  );

  modport slave (
    input  raw_in,
    input  ack,
    output req_onehot,
    output req_valid,
`ifdef LINE_REQ_OVERRUN_EN
    output overrun,
`endif
    output pending
  );
endinterface

// File: rtl/line_request_latch.sv
// Synchronize, debounce and latch eight request lines; present one at a time
// round-robin as a one-hot with valid/ack. Optional LINE_REQ_OVERRUN_EN adds sticky overrun flags.
module line_request_latch #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  line_request_latch_if.slave bus
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [7:0]    s1;
  logic [7:0]    s2;
  logic [7:0]    stable;
  logic [7:0]    stable_d;
  logic [CW-1:0] cnt [8];
  logic [7:0]    rise;
  logic [7:0]    clr;
  logic [7:0]    pending_q;
  logic [7:0]    pending_next;
  logic [7:0]    onehot_q;
  logic          valid_q;
  logic [0:0]    state;
  logic [2:0]    ptr;
  logic [2:0]    gidx;
  logic [2:0]    pick;
  logic [2:0]    idx;
  logic          found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.raw_in;
      s2 <= s1;
    end
  end

  // stable flips on the DEB_CYCLES-th consecutive cycle of disagreement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable   <= '0;
      stable_d <= '0;
      for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int unsigned i = 0; i < 8; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = stable & ~stable_d;

  always_comb begin
    clr = '0;
    if (state == PRESENT && bus.ack) clr = onehot_q;
  end

  assign pending_next = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_next;
  end

  // first set pending bit at or above ptr, wrapping 7 -> 0
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      ptr      <= '0;
      gidx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            onehot_q <= 8'b1 << pick;
            gidx     <= pick;
            valid_q  <= 1'b1;
            state    <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.ack) begin
            onehot_q <= '0;
            valid_q  <= 1'b0;
            ptr      <= gidx + 3'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_REQ_OVERRUN_EN
  logic [7:0] overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= '0;
    else     overrun_q <= overrun_q | (rise & pending_q & ~clr);
  end

  assign bus.overrun = overrun_q;
`endif

  assign bus.req_onehot = onehot_q;
  assign bus.req_valid  = valid_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_line_request_latch.sv
// Scoreboard bench for line_request_latch (DEB_CYCLES=4); expected grants are
// queued as stimulus is driven and popped as grants appear.
module tb_line_request_latch;

  logic clk;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0] exp_q [$];

  line_request_latch_if bus ();

  line_request_latch #(.DEB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // waits (bounded) for req_valid and compares the grant to the scoreboard head
  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!bus.req_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_valid"}, 32'(bus.req_valid), 32'd1);
    check({tag, "_onehot"}, 32'(bus.req_onehot), 32'(pop_exp()));
  endtask

  task automatic ack_once(input string tag);
    @(negedge clk);
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ack_drop"}, 32'(bus.req_valid), 32'd0);
    @(negedge clk);
    bus.ack = 1'b0;
  endtask

  initial begin
    int unsigned cyc;
    int unsigned last;
    int unsigned seen;

    rst        = 1'b1;
    bus.raw_in = '0;
    bus.ack    = 1'b0;
    #12;
    check("rst_onehot", 32'(bus.req_onehot), 32'd0);
    check("rst_valid", 32'(bus.req_valid), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
`ifdef LINE_REQ_OVERRUN_EN
    check("rst_overrun", 32'(bus.overrun), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick(3);

    // single clean edge on line 3, exact latency
    @(negedge clk);
    bus.raw_in = 8'h08;
    exp_q.push_back(8'h08);
    tick(6);
    check("lat_pend_e5", 32'(bus.pending), 32'h00);
    tick(1);
    check("lat_pend_e6", 32'(bus.pending), 32'h08);
    check("lat_valid_e6", 32'(bus.req_valid), 32'd0);
    tick(1);
    check("lat_valid_e7", 32'(bus.req_valid), 32'd1);
    check("lat_onehot_e7", 32'(bus.req_onehot), 32'(pop_exp()));
    ack_once("lat");
    check("lat_pend_cleared", 32'(bus.pending), 32'h00);
    bus.raw_in = 8'h00;
    tick(10);

    // bounce on line 2: 3 high, 1 low, then steady high
    @(negedge clk); bus.raw_in = 8'h04;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.raw_in = 8'h00;
    @(negedge clk); bus.raw_in = 8'h04;
    #1;
    check("bounce_quiet", 32'(bus.pending), 32'h00);
    exp_q.push_back(8'h04);
    wait_valid("bounce");
    ack_once("bounce");
    tick(20);
    check("bounce_single_valid", 32'(bus.req_valid), 32'd0);
    check("bounce_single_pend", 32'(bus.pending), 32'h00);
    @(negedge clk);
    bus.raw_in = 8'h00;
    tick(10);

    // reset while presenting with pending = 05 (ptr = 3 so line 0 wins)
    @(negedge clk);
    bus.raw_in = 8'h05;
    exp_q.push_back(8'h01);
    wait_valid("rstp");
    check("rstp_pending", 32'(bus.pending), 32'h05);
    @(posedge clk);
    #2;
    rst        = 1'b1;
    bus.raw_in = 8'h00;
    #1;
    check("rstp_onehot", 32'(bus.req_onehot), 32'd0);
    check("rstp_valid", 32'(bus.req_valid), 32'd0);
    check("rstp_pending0", 32'(bus.pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(20);
    check("rstp_idle_valid", 32'(bus.req_valid), 32'd0);
    check("rstp_idle_pend", 32'(bus.pending), 32'd0);

    // round-robin with ack held high
    @(negedge clk);
    bus.raw_in = 8'hA5;
    bus.ack    = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h80);
    cyc  = 0;
    last = 0;
    seen = 0;
    while (seen < 4 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.req_valid) begin
        if (seen > 0) check("rr_gap", cyc - last, 32'd2);
        check("rr_onehot", 32'(bus.req_onehot), 32'(pop_exp()));
        last = cyc;
        seen++;
      end
    end
    check("rr_count", seen, 32'd4);
    tick(1);
    check("rr_drained", 32'(bus.req_valid), 32'd0);
    @(negedge clk);
    bus.ack    = 1'b0;
    bus.raw_in = 8'h00;
    tick(10);

    // ptr wrapped to 0: line 0 ahead of line 7
    @(negedge clk);
    bus.raw_in = 8'h81;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    wait_valid("wrap0");
    ack_once("wrap0");
    wait_valid("wrap7");
    ack_once("wrap7");
    @(negedge clk);
    bus.raw_in = 8'h00;
    tick(10);

    // line 3 re-rises in the exact cycle its grant is acked
    @(negedge clk);
    bus.raw_in = 8'h08;
    exp_q.push_back(8'h08);
    wait_valid("col_first");
    @(negedge clk);
    bus.raw_in = 8'h00;
    tick(10);
    @(negedge clk);
    bus.raw_in = 8'h08;
    exp_q.push_back(8'h08);
    repeat (6) @(posedge clk);
    #1;
    check("col_pre_valid", 32'(bus.req_valid), 32'd1);
    @(negedge clk);
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    check("col_pend_kept", 32'(bus.pending), 32'h08);
    check("col_valid_drop", 32'(bus.req_valid), 32'd0);
    @(negedge clk);
    bus.ack = 1'b0;
    wait_valid("col_again");
    ack_once("col_again");
    check("col_pend_done", 32'(bus.pending), 32'h00);
    @(negedge clk);
    bus.raw_in = 8'h00;
    tick(10);

    // line 5 rises twice while held un-acked
    @(negedge clk);
    bus.raw_in = 8'h20;
    exp_q.push_back(8'h20);
    wait_valid("ov_grant");
    @(negedge clk);
    bus.raw_in = 8'h00;
    tick(10);
    @(negedge clk);
    bus.raw_in = 8'h20;
    tick(10);
    check("ov_pend_merged", 32'(bus.pending), 32'h20);
`ifdef LINE_REQ_OVERRUN_EN
    check("ov_flag", 32'(bus.overrun), 32'h20);
`endif
    ack_once("ov");
    tick(20);
    check("ov_no_second_valid", 32'(bus.req_valid), 32'd0);
    check("ov_no_second_pend", 32'(bus.pending), 32'h00);
`ifdef LINE_REQ_OVERRUN_EN
    check("ov_sticky", 32'(bus.overrun), 32'h20);
`endif
    check("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
